// File: rtl/mac_neg_pipe_pkg.sv
// Shared cfg encodings and lane-grouping helpers for the MAC sign-to-magnitude front end.
package mac_neg_pipe_pkg;

  typedef enum logic [1:0] {
    MAC_MODE_SINGLE = 2'b00,
    MAC_MODE_DUAL   = 2'b01,
    MAC_MODE_QUAD   = 2'b10,
    MAC_MODE_RSVD   = 2'b11
  } mac_mode_e;

  localparam int unsigned MAC_CFG_SIGNED_BIT = 3;

  // Carry from lane i into lane i+1 is allowed only when both lanes share a group.
  function automatic logic link_en(mac_mode_e mode, int unsigned i);
    return ((mode == MAC_MODE_DUAL) && (i % 2 == 0)) ||
           ((mode == MAC_MODE_QUAD) && (i % 4 != 3));
  endfunction

  // Index of the top lane of the group containing lane i.
  function automatic int unsigned group_top(mac_mode_e mode, int unsigned i);
    case (mode)
      MAC_MODE_DUAL: return i | 1;
      MAC_MODE_QUAD: return i | 3;
      default:       return i;
    endcase
  endfunction

endpackage

// File: rtl/mac_neg_pipe_if.sv
// Handshake and operand bus of mac_neg_pipe; slave is the DUT side, master the driver side.
interface mac_neg_pipe_if #(
  parameter int unsigned CW = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [CW-1:0]  in_cfg;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_cfg;
  logic [N*W-1:0] a_out;
  logic [N*W-1:0] b_out;
  logic [N-1:0]   neg_out;

  modport slave (
    input  in_valid, in_cfg, a_in, b_in, out_ready,
    output in_ready, out_valid, out_cfg, a_out, b_out, neg_out
  );

  modport master (
    output in_valid, in_cfg, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_cfg, a_out, b_out, neg_out
  );
endinterface

// File: rtl/mac_neg_group_chain.sv
// One operand, N lanes: per-lane incrementer of the inverted lane with mode-gated carry links,
// selecting the negated or original lane according to the group sign.
module mac_neg_group_chain
  import mac_neg_pipe_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic [N*W-1:0] x_i,
  input  mac_mode_e      mode_i,
  input  logic           signed_i,
  output logic [N*W-1:0] y_o,
  output logic [N-1:0]   sign_o
);

  logic [N-1:0]   cin;
  logic [N-1:0]   cout;
  logic [N*W-1:0] neg;

  always_comb begin
    cin    = '0;
    cout   = '0;
    neg    = '0;
    y_o    = '0;
    sign_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Group base lanes inject the +1; upper lanes take the carry of the lane below.
      cin[i] = (i == 0) ? 1'b1 : (link_en(mode_i, i - 1) ? cout[i-1] : 1'b1);
      {cout[i], neg[i*W +: W]} = {1'b0, ~x_i[i*W +: W]} + {{W{1'b0}}, cin[i]};
      sign_o[i] = x_i[group_top(mode_i, i)*W + W - 1];
      y_o[i*W +: W] = (signed_i && sign_o[i]) ? neg[i*W +: W] : x_i[i*W +: W];
    end
  end

endmodule

// File: rtl/mac_neg_pipe.sv
// Two-stage valid/ready pipeline converting grouped signed A/B operand lanes to magnitudes
// with a per-lane product-sign flag; cfg travels with each beat.
module mac_neg_pipe
  import mac_neg_pipe_pkg::*;
#(
  parameter int unsigned MAC_CONF_WIDTH = 4,
  parameter int unsigned MAC_MIN_WIDTH  = 8,
  parameter int unsigned NUM_LANES      = 4
) (
  input  logic         clk,
  input  logic         rst,
  mac_neg_pipe_if.slave bus
);

  localparam int unsigned W  = MAC_MIN_WIDTH;
  localparam int unsigned N  = NUM_LANES;
  localparam int unsigned CW = MAC_CONF_WIDTH;
  localparam int unsigned DW = N * W;

  logic          s1_valid_q;
  logic [CW-1:0] s1_cfg_q;
  logic [DW-1:0] s1_a_q;
  logic [DW-1:0] s1_b_q;

  logic          s2_valid_q;
  logic [CW-1:0] s2_cfg_q;
  logic [DW-1:0] s2_a_q;
  logic [DW-1:0] s2_b_q;
  logic [N-1:0]  s2_neg_q;

  logic          s1_load;
  logic          s2_load;
  mac_mode_e     s1_mode;
  logic          s1_signed;
  logic [DW-1:0] a_d;
  logic [DW-1:0] b_d;
  logic [N-1:0]  sign_a;
  logic [N-1:0]  sign_b;
  logic [N-1:0]  neg_d;

  assign s2_load     = ~s2_valid_q | bus.out_ready;
  assign s1_load     = ~s1_valid_q | s2_load;
  assign bus.in_ready = ~rst & s1_load;

  assign s1_mode   = mac_mode_e'(s1_cfg_q[1:0]);
  assign s1_signed = s1_cfg_q[MAC_CFG_SIGNED_BIT];

  mac_neg_group_chain #(.W(W), .N(N)) u_chain_a (
    .x_i      (s1_a_q),
    .mode_i   (s1_mode),
    .signed_i (s1_signed),
    .y_o      (a_d),
    .sign_o   (sign_a)
  );

  mac_neg_group_chain #(.W(W), .N(N)) u_chain_b (
    .x_i      (s1_b_q),
    .mode_i   (s1_mode),
    .signed_i (s1_signed),
    .y_o      (b_d),
    .sign_o   (sign_b)
  );

  assign neg_d = {N{s1_signed}} & (sign_a ^ sign_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cfg_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_cfg_q   <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_neg_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_cfg_q <= bus.in_cfg;
          s1_a_q   <= bus.a_in;
          s1_b_q   <= bus.b_in;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_cfg_q <= s1_cfg_q;
          s2_a_q   <= a_d;
          s2_b_q   <= b_d;
          s2_neg_q <= neg_d;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_cfg   = s2_cfg_q;
  assign bus.a_out     = s2_a_q;
  assign bus.b_out     = s2_b_q;
  assign bus.neg_out   = s2_neg_q;

endmodule

// File: tb/tb_mac_neg_pipe.sv
// Self-checking bench for mac_neg_pipe: directed table, stall/reset sequences, randomized
// traffic scored against a group-arithmetic reference model.
module tb_mac_neg_pipe;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int DW = N * W;

  typedef struct {
    logic [3:0]    cfg;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [N-1:0]  en;
  } vec_t;

  typedef struct {
    logic [3:0]    cfg;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [N-1:0]  neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  mac_neg_pipe_if #(.CW(4), .W(W), .N(N)) bus ();

  mac_neg_pipe #(
    .MAC_CONF_WIDTH (4),
    .MAC_MIN_WIDTH  (W),
    .NUM_LANES      (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each group is treated as one W*g-bit integer and negated modulo 2^(W*g).
  function automatic exp_t model(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t            e;
    int              g;
    int              gw;
    longint unsigned mask, va, vb;
    logic            sgn_a, sgn_b;
    g  = (c[1:0] == 2'b10) ? 4 : (c[1:0] == 2'b01) ? 2 : 1;
    gw = g * W;
    mask = (64'd1 << gw) - 64'd1;
    e.cfg = c;
    e.a   = '0;
    e.b   = '0;
    e.neg = '0;
    for (int gi = 0; gi < N / g; gi++) begin
      va = (64'(a) >> (gi * gw)) & mask;
      vb = (64'(b) >> (gi * gw)) & mask;
      sgn_a = va[gw-1];
      sgn_b = vb[gw-1];
      if (c[3] && sgn_a) va = (~va + 64'd1) & mask;
      if (c[3] && sgn_b) vb = (~vb + 64'd1) & mask;
      e.a |= DW'(va << (gi * gw));
      e.b |= DW'(vb << (gi * gw));
      for (int l = 0; l < g; l++) e.neg[gi*g + l] = c[3] & (sgn_a ^ sgn_b);
    end
    return e;
  endfunction

  // Drive one cycle's inputs, score any pop and record any push that the coming edge performs.
  task automatic drive_cycle(input logic v, input logic [3:0] c, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic ordy, input exp_t e,
                             output logic acc);
    exp_t f;
    bus.in_valid  = v;
    bus.in_cfg    = c;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_out: got out_valid=1 expected no pending beat at %0t", $time);
      end else begin
        f = sb.pop_front();
        chk("a_out",   64'(bus.a_out),   64'(f.a));
        chk("b_out",   64'(bus.b_out),   64'(f.b));
        chk("neg_out", 64'(bus.neg_out), 64'(f.neg));
        chk("out_cfg", 64'(bus.out_cfg), 64'(f.cfg));
      end
    end
    acc = v && bus.in_ready;
    if (acc) sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic latency(input vec_t t);
    exp_t e;
    logic acc;
    e.cfg = t.cfg; e.a = t.ea; e.b = t.eb; e.neg = t.en;
    drive_cycle(1'b1, t.cfg, t.a, t.b, 1'b1, e, acc);
    chk("lat_accept", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    #1;
    chk("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, e, acc);
    chk("lat_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic          acc, have;
    logic [3:0]    c;
    logic [DW-1:0] a, b;
    exp_t          e, snap;
    exp_t          pend[4];
    int            np;

    tbl[0] = '{4'b1000, 32'h0005FF80, 32'h01010101, 32'h00050180, 32'h01010101, 4'b0011};
    tbl[1] = '{4'b1010, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000003, 4'b1111};
    tbl[2] = '{4'b1001, 32'h8000FFFF, 32'h00000000, 32'h80000001, 32'h00000000, 4'b1111};
    tbl[3] = '{4'b0001, 32'h8000FFFF, 32'h00000000, 32'h8000FFFF, 32'h00000000, 4'b0000};
    tbl[4] = '{4'b1000, 32'hFF7F0080, 32'h80FF0101, 32'h017F0080, 32'h80010101, 4'b0101};
    tbl[5] = '{4'b1010, 32'hFF7F0080, 32'h00000000, 32'h0080FF80, 32'h00000000, 4'b1111};
    tbl[6] = '{4'b1101, 32'hFF7F0080, 32'h00000000, 32'h00810080, 32'h00000000, 4'b1100};
    tbl[7] = '{4'b1011, 32'hFF7F0080, 32'h80FF0101, 32'h017F0080, 32'h80010101, 4'b0101};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_cfg = '0; bus.a_in = '0; bus.b_in = '0; bus.out_ready = 1'b1;
    e = '{default: '0};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_a_out",     64'(bus.a_out),     64'd0);
    chk("rst_neg_out",   64'(bus.neg_out),   64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, one at a time, with exact two-cycle latency.
    for (int i = 0; i < 8; i++) latency(tbl[i]);

    // Same vectors back-to-back: every beat must carry its own cfg.
    for (int i = 0; i < 8; i++) begin
      e.cfg = tbl[i].cfg; e.a = tbl[i].ea; e.b = tbl[i].eb; e.neg = tbl[i].en;
      drive_cycle(1'b1, tbl[i].cfg, tbl[i].a, tbl[i].b, 1'b1, e, acc);
      chk("b2b_accept", 64'(acc), 64'd1);
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++) drive_cycle(1'b0, '0, '0, '0, 1'b1, e, acc);
    chk("b2b_drained", 64'(sb.size()), 64'd0);

    // Stall: 4 offered beats with out_ready low; only two fit.
    for (int i = 0; i < 4; i++) pend[i] = model(4'($urandom), DW'($urandom), DW'($urandom));
    np = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, pend[np].cfg, tbl[np].a ^ DW'(np), tbl[np].b, 1'b0,
                  model(pend[np].cfg, tbl[np].a ^ DW'(np), tbl[np].b), acc);
      chk("stall_in_ready", 64'(acc), (k < 2) ? 64'd1 : 64'd0);
      if (acc) np++;
      if (k == 1) begin
        snap.a = bus.a_out; snap.b = bus.b_out; snap.neg = bus.neg_out; snap.cfg = bus.out_cfg;
      end
    end
    chk("stall_valid",  64'(bus.out_valid), 64'd1);
    chk("stall_hold_a", 64'(bus.a_out),   64'(snap.a));
    chk("stall_hold_b", 64'(bus.b_out),   64'(snap.b));
    chk("stall_hold_n", 64'(bus.neg_out), 64'(snap.neg));
    chk("stall_hold_c", 64'(bus.out_cfg), 64'(snap.cfg));
    for (int k = 0; k < 20 && (np < 4 || sb.size() != 0); k++) begin
      if (np < 4) begin
        drive_cycle(1'b1, pend[np].cfg, tbl[np].a ^ DW'(np), tbl[np].b, 1'b1,
                    model(pend[np].cfg, tbl[np].a ^ DW'(np), tbl[np].b), acc);
        if (acc) np++;
      end else begin
        drive_cycle(1'b0, '0, '0, '0, 1'b1, e, acc);
      end
    end
    chk("stall_all_accepted", 64'(np), 64'd4);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full discards everything.
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, tbl[i].cfg, tbl[i].a, tbl[i].b, 1'b0, e, acc);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_a_out",     64'(bus.a_out),     64'd0);
    chk("midrst_b_out",     64'(bus.b_out),     64'd0);
    chk("midrst_neg_out",   64'(bus.neg_out),   64'd0);
    chk("midrst_out_cfg",   64'(bus.out_cfg),   64'd0);
    chk("midrst_in_ready1", 64'(bus.in_ready),  64'd1);
    sb.delete();
    @(negedge clk);
    latency(tbl[4]);

    // Random traffic with random backpressure; beats held until accepted.
    have = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!have) begin
        c = 4'($urandom); a = DW'($urandom); b = DW'($urandom); have = 1'b1;
      end
      drive_cycle($urandom_range(0, 9) < 7, c, a, b, $urandom_range(0, 9) < 6, model(c, a, b), acc);
      if (acc) have = 1'b0;
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) drive_cycle(1'b0, '0, '0, '0, 1'b1, e, acc);
    chk("rand_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
